// File: rtl/hyper_pkg.sv
// Shared types and constants for the HyperBus PHY transmit path.
package hyper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CA,
    ST_LAT,
    ST_DATA,
    ST_END
  } tx_state_e;

  localparam int CA_RW_BIT = 47;
  localparam int CA_AS_BIT = 46;
  localparam int CA_WORDS  = 3;

endpackage

// File: rtl/hyper_ddr_out.sv
// Clock-selected DDR output mux: high byte / RWDS[1] while clk_i=1, low half while clk_i=0.
module hyper_ddr_out (
  input  logic        clk_i,
  input  logic [15:0] word_i,
  input  logic [1:0]  mask_i,
  output logic [7:0]  dq_o,
  output logic        rwds_o
);

  assign dq_o   = clk_i ? word_i[15:8] : word_i[7:0];
  assign rwds_o = clk_i ? mask_i[1]    : mask_i[0];

endmodule

// File: rtl/hyper_ddr_tx.sv
// HyperBus transmit sequencer: CA, initial latency and masked write data onto DDR DQ/RWDS.
module hyper_ddr_tx
  import hyper_pkg::*;
#(
  parameter int LAT_CYCLES = 6
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        trans_valid_i,
  output logic        trans_ready_o,
  input  logic [47:0] ca_i,
  input  logic        double_lat_i,
  input  logic        data_valid_i,
  output logic        data_ready_o,
  input  logic [15:0] data_i,
  input  logic [1:0]  strb_i,
  input  logic        last_i,
  output logic        cs_no,
  output logic [7:0]  dq_o,
  output logic        dq_oe_o,
  output logic        rwds_o,
  output logic        rwds_oe_o,
  output logic        done_o,
  output logic        err_o,
  output tx_state_e   dbg_state_o
);

  localparam int CNT_W = $clog2(2 * LAT_CYCLES + 1);
  localparam int IDX_W = $clog2(CA_WORDS + 1);

  // Valid/ready: a transfer happens on a rising edge where both are high;
  // ready depends only on the FSM state, never on valid.
  tx_state_e          state;
  logic [47:0]        ca_sr;
  logic               is_read;
  logic               is_reg;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;
  logic [15:0]        word_q;
  logic [1:0]         mask_q;

  assign trans_ready_o = (state == ST_IDLE);
  assign data_ready_o  = (state == ST_DATA);
  assign dbg_state_o   = state;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ST_IDLE;
      ca_sr     <= '0;
      is_read   <= 1'b0;
      is_reg    <= 1'b0;
      idx       <= '0;
      cnt       <= '0;
      word_q    <= '0;
      mask_q    <= '0;
      cs_no     <= 1'b1;
      dq_oe_o   <= 1'b0;
      rwds_oe_o <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (trans_valid_i) begin
            is_read <= ca_i[CA_RW_BIT];
            is_reg  <= ca_i[CA_AS_BIT];
            cnt     <= double_lat_i ? CNT_W'(2 * LAT_CYCLES) : CNT_W'(LAT_CYCLES);
            ca_sr   <= {ca_i[31:0], 16'h0000};
            word_q  <= ca_i[47:32];
            mask_q  <= 2'b00;
            idx     <= IDX_W'(1);
            cs_no   <= 1'b0;
            dq_oe_o <= 1'b1;
            state   <= ST_CA;
          end
        end
        ST_CA: begin
          word_q <= ca_sr[47:32];
          ca_sr  <= {ca_sr[31:0], 16'h0000};
          idx    <= idx + IDX_W'(1);
          // The last CA word is being loaded; it is on the pins in the next state.
          if (idx == IDX_W'(CA_WORDS - 1)) begin
            if (is_read)     state <= ST_END;
            else if (is_reg) state <= ST_DATA;
            else             state <= ST_LAT;
          end
        end
        ST_LAT: begin
          dq_oe_o <= 1'b0;
          if (cnt == CNT_W'(1)) begin
            rwds_oe_o <= 1'b1;
            mask_q    <= 2'b11;
            state     <= ST_DATA;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (data_valid_i) begin
            word_q    <= data_i;
            mask_q    <= ~strb_i;
            dq_oe_o   <= 1'b1;
            rwds_oe_o <= 1'b1;
            if (last_i) state <= ST_END;
          end else begin
            // A write burst cannot be stalled, so a missing word aborts it.
            err_o     <= 1'b1;
            cs_no     <= 1'b1;
            dq_oe_o   <= 1'b0;
            rwds_oe_o <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_END: begin
          cs_no     <= 1'b1;
          dq_oe_o   <= 1'b0;
          rwds_oe_o <= 1'b0;
          done_o    <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  hyper_ddr_out u_ddr_out (
    .clk_i  (clk_i),
    .word_i (word_q),
    .mask_i (mask_q),
    .dq_o   (dq_o),
    .rwds_o (rwds_o)
  );

endmodule

// File: tb/tb_hyper_ddr_tx.sv
// Self-checking bench for hyper_ddr_tx: directed protocol cases plus randomized transactions.
module tb_hyper_ddr_tx;
  import hyper_pkg::*;

  localparam int LAT = 6;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        trans_valid_i = 1'b0;
  logic        trans_ready_o;
  logic [47:0] ca_i = '0;
  logic        double_lat_i = 1'b0;
  logic        data_valid_i = 1'b0;
  logic        data_ready_o;
  logic [15:0] data_i = '0;
  logic [1:0]  strb_i = '0;
  logic        last_i = 1'b0;
  logic        cs_no;
  logic [7:0]  dq_o;
  logic        dq_oe_o;
  logic        rwds_o;
  logic        rwds_oe_o;
  logic        done_o;
  logic        err_o;
  tx_state_e   dbg_state_o;

  hyper_ddr_tx #(.LAT_CYCLES(LAT)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .trans_valid_i (trans_valid_i),
    .trans_ready_o (trans_ready_o),
    .ca_i          (ca_i),
    .double_lat_i  (double_lat_i),
    .data_valid_i  (data_valid_i),
    .data_ready_o  (data_ready_o),
    .data_i        (data_i),
    .strb_i        (strb_i),
    .last_i        (last_i),
    .cs_no         (cs_no),
    .dq_o          (dq_o),
    .dq_oe_o       (dq_oe_o),
    .rwds_o        (rwds_o),
    .rwds_oe_o     (rwds_oe_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .dbg_state_o   (dbg_state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // expected pin state for one clk_i cycle
  typedef struct {
    logic        cs;
    logic        dq_oe;
    logic        rwds_oe;
    logic        chk_dq;
    logic [15:0] w;
    logic        chk_m;
    logic [1:0]  m;
    logic        done;
    logic        err;
    logic        rdy;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] wd [0:7];
  logic [1:0]  sb [0:7];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_e(input logic cs, input logic dq_oe, input logic rwds_oe,
                        input logic chk_dq, input logic [15:0] w,
                        input logic chk_m, input logic [1:0] m,
                        input logic done, input logic err, input logic rdy);
    exp_t e;
    e.cs = cs; e.dq_oe = dq_oe; e.rwds_oe = rwds_oe; e.chk_dq = chk_dq; e.w = w;
    e.chk_m = chk_m; e.m = m; e.done = done; e.err = err; e.rdy = rdy;
    exp_q.push_back(e);
  endtask

  // Reference model: pin trace from the first cycle after CA acceptance.
  task automatic build_exp(input logic [47:0] ca, input logic dbl, input int n, input int k);
    int l;
    int acc;
    l = dbl ? 2 * LAT : LAT;
    acc = (k < n) ? k : n;
    exp_q.delete();
    for (int i = 0; i < CA_WORDS; i++)
      push_e(1'b0, 1'b1, 1'b0, 1'b1, ca[47-16*i -: 16], 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    if (ca[CA_RW_BIT]) begin
      push_e(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
    end else begin
      if (!ca[CA_AS_BIT])
        for (int j = 1; j <= l; j++)
          push_e(1'b0, 1'b0, (j == l), 1'b0, 16'h0, (j == l), 2'b11, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < acc; i++)
        push_e(1'b0, 1'b1, 1'b1, 1'b1, wd[i], 1'b1, ~sb[i], 1'b0, 1'b0, 1'b0);
      if (k < n) push_e(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
      else       push_e(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
    end
    push_e(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic drive_data(input int acc, input int n, input int k);
    data_valid_i = (acc < n) && (acc < k);
    data_i       = (acc < n) ? wd[acc] : 16'h0;
    strb_i       = (acc < n) ? sb[acc] : 2'b00;
    last_i       = (acc == n - 1);
  endtask

  // Driver + checker: issue one transaction and compare every cycle against exp_q.
  // k = number of words supplied before data_valid_i drops (k >= n means no underrun).
  task automatic run_txn(input string tag, input logic [47:0] ca, input logic dbl,
                         input int n, input int k);
    int  acc;
    int  t;
    int  wait_cyc;
    logic fire;
    exp_t e;
    build_exp(ca, dbl, n, k);
    wait_cyc = 0;
    while (!trans_ready_o && wait_cyc < 40) begin
      @(posedge clk_i); #1;
      wait_cyc++;
    end
    chk({tag, "_ready_timeout"}, {15'h0, trans_ready_o}, 16'h1);
    acc = 0;
    trans_valid_i = 1'b1;
    ca_i = ca;
    double_lat_i = dbl;
    drive_data(acc, n, k);
    @(posedge clk_i); #1;
    trans_valid_i = 1'b0;
    ca_i = {$urandom, $urandom};
    double_lat_i = $urandom_range(0, 1);
    t = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("%s_cs_t%0d", tag, t), {15'h0, cs_no}, {15'h0, e.cs});
      chk($sformatf("%s_dqoe_t%0d", tag, t), {15'h0, dq_oe_o}, {15'h0, e.dq_oe});
      chk($sformatf("%s_rwdsoe_t%0d", tag, t), {15'h0, rwds_oe_o}, {15'h0, e.rwds_oe});
      chk($sformatf("%s_done_t%0d", tag, t), {15'h0, done_o}, {15'h0, e.done});
      chk($sformatf("%s_err_t%0d", tag, t), {15'h0, err_o}, {15'h0, e.err});
      chk($sformatf("%s_rdy_t%0d", tag, t), {15'h0, trans_ready_o}, {15'h0, e.rdy});
      if (ca[CA_RW_BIT])
        chk($sformatf("%s_nodata_t%0d", tag, t), {15'h0, (dbg_state_o == ST_DATA)}, 16'h0);
      if (e.chk_dq) chk($sformatf("%s_dqhi_t%0d", tag, t), {8'h0, dq_o}, {8'h0, e.w[15:8]});
      if (e.chk_m)  chk($sformatf("%s_rwhi_t%0d", tag, t), {15'h0, rwds_o}, {15'h0, e.m[1]});
      drive_data(acc, n, k);
      @(negedge clk_i); #1;
      if (e.chk_dq) chk($sformatf("%s_dqlo_t%0d", tag, t), {8'h0, dq_o}, {8'h0, e.w[7:0]});
      if (e.chk_m)  chk($sformatf("%s_rwlo_t%0d", tag, t), {15'h0, rwds_o}, {15'h0, e.m[0]});
      fire = data_valid_i && data_ready_o;
      @(posedge clk_i); #1;
      if (fire) acc++;
      t++;
    end
    data_valid_i = 1'b0;
    last_i = 1'b0;
  endtask

  initial begin
    int n;
    int k;
    logic [47:0] ca;

    // reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_cs", {15'h0, cs_no}, 16'h1);
    chk("rst_dqoe", {15'h0, dq_oe_o}, 16'h0);
    chk("rst_rwdsoe", {15'h0, rwds_oe_o}, 16'h0);
    chk("rst_dq", {8'h0, dq_o}, 16'h0);
    chk("rst_rwds", {15'h0, rwds_o}, 16'h0);
    chk("rst_done", {15'h0, done_o}, 16'h0);
    chk("rst_err", {15'h0, err_o}, 16'h0);
    chk("rst_state", {13'h0, dbg_state_o}, {13'h0, ST_IDLE});
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // read
    run_txn("read", 48'hA000_0000_0010, 1'b0, 0, 0);

    // write, single and double latency
    wd[0] = 16'h1122; sb[0] = 2'b11;
    wd[1] = 16'h3344; sb[1] = 2'b11;
    run_txn("wr_lat1x", 48'h2000_0000_0004, 1'b0, 2, 2);
    run_txn("wr_lat2x", 48'h2000_0000_0004, 1'b1, 2, 2);

    // zero-latency register write
    wd[0] = 16'h8F1F; sb[0] = 2'b11;
    run_txn("reg_wr", 48'h6000_0100_0000, 1'b0, 1, 1);

    // partial strobe
    wd[0] = 16'hABCD; sb[0] = 2'b10;
    run_txn("strb10", 48'h2000_0000_0008, 1'b0, 1, 1);

    // underrun in the 2nd DATA cycle
    wd[0] = 16'h5566; sb[0] = 2'b11;
    wd[1] = 16'h7788; sb[1] = 2'b01;
    wd[2] = 16'h99AA; sb[2] = 2'b11;
    run_txn("underrun", 48'h2000_0000_0040, 1'b0, 3, 1);

    // reset asserted mid-latency
    trans_valid_i = 1'b1;
    ca_i = 48'h2000_0000_0100;
    double_lat_i = 1'b1;
    @(posedge clk_i); #1;
    trans_valid_i = 1'b0;
    repeat (6) @(posedge clk_i);
    #1;
    chk("midlat_pre_dqoe", {15'h0, dq_oe_o}, 16'h0);
    chk("midlat_pre_cs", {15'h0, cs_no}, 16'h0);
    rst_ni = 1'b0;
    #1;
    chk("midlat_cs", {15'h0, cs_no}, 16'h1);
    chk("midlat_dqoe", {15'h0, dq_oe_o}, 16'h0);
    chk("midlat_rwdsoe", {15'h0, rwds_oe_o}, 16'h0);
    chk("midlat_dq", {8'h0, dq_o}, 16'h0);
    chk("midlat_rwds", {15'h0, rwds_o}, 16'h0);
    chk("midlat_done", {15'h0, done_o}, 16'h0);
    chk("midlat_err", {15'h0, err_o}, 16'h0);
    chk("midlat_state", {13'h0, dbg_state_o}, {13'h0, ST_IDLE});
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    wd[0] = 16'hC0DE; sb[0] = 2'b01;
    wd[1] = 16'hBEEF; sb[1] = 2'b00;
    run_txn("post_rst", 48'h2000_0000_0200, 1'b0, 2, 2);

    // randomized transactions
    for (int r = 0; r < 25; r++) begin
      ca = {$urandom, $urandom};
      n = $urandom_range(1, 4);
      k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : n;
      for (int i = 0; i < n; i++) begin
        wd[i] = $urandom;
        sb[i] = $urandom_range(0, 3);
      end
      run_txn($sformatf("rnd%0d", r), ca, $urandom_range(0, 1), n, k);
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached");
    $fatal(1, "timeout");
  end

endmodule
